// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin owner of a shared 802.11a transmitter.
// Fires Start, waits out the PLCP header, streams the PSDU, then applies trailer and IFS gap.
module tx_frame_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned HEADER_CYCLES  = 139,
    parameter int unsigned PSDU_BITS      = 128,
    parameter int unsigned TRAILER_CYCLES = 2,
    parameter int unsigned GAP_CYCLES     = 16,
    localparam int unsigned IDW           = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_data,
    input  logic               i_abort,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grant_id,
    output logic [NUM_REQ-1:0] o_data_ack,
    output logic               o_tx_start,
    output logic               o_tx_input,
    output logic               o_tx_reset,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int unsigned MAX_A     = (HEADER_CYCLES > PSDU_BITS) ? HEADER_CYCLES : PSDU_BITS;
    localparam int unsigned MAX_B     = (TRAILER_CYCLES > GAP_CYCLES) ? TRAILER_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    // START already consumes one of the header edges, so HEADER itself lasts HEADER_CYCLES-1 cycles.
    localparam int unsigned HDR_LAST  = (HEADER_CYCLES > 1) ? HEADER_CYCLES - 2 : 0;
    localparam int unsigned PSDU_LAST = (PSDU_BITS > 0) ? PSDU_BITS - 1 : 0;
    localparam int unsigned TRL_LAST  = (TRAILER_CYCLES > 0) ? TRAILER_CYCLES - 1 : 0;
    localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned LAST_ID   = NUM_REQ - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HEADER,
        S_PSDU,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant_id;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_start;
    logic               r_tx_reset;

    logic               w_any_req;
    logic [IDW-1:0]     w_sel_id;
    logic [IDW-1:0]     w_idx;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [IDW-1:0]     w_next_ptr;
    logic               w_psdu_last;
    logic               w_trail_last;
    logic               w_gap_last;
    logic               w_finish;
    state_t             w_after_frame;

    always_comb begin
        w_any_req = 1'b0;
        w_sel_id  = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any_req && i_req[w_idx]) begin
                w_any_req = 1'b1;
                w_sel_id  = w_idx;
            end
        end
    end

    assign w_sel_onehot  = NUM_REQ'(1) << w_sel_id;
    assign w_next_ptr    = (r_grant_id == IDW'(LAST_ID)) ? '0 : r_grant_id + 1'b1;
    assign w_psdu_last   = (r_state == S_PSDU)  && (r_cnt == CW'(PSDU_LAST));
    assign w_trail_last  = (r_state == S_TRAIL) && (r_cnt == CW'(TRL_LAST));
    assign w_gap_last    = (r_state == S_GAP)   && (r_cnt == CW'(GAP_LAST));
    assign w_finish      = (w_psdu_last && (TRAILER_CYCLES == 0)) || w_trail_last;
    assign w_after_frame = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_tx_start <= 1'b0;
            r_tx_reset <= 1'b1;
        end else begin
            r_tx_start <= 1'b0;
            r_tx_reset <= 1'b0;
            // Abort is checked first so it beats completion on the last PSDU/TRAIL cycle.
            if (i_abort && (r_state != S_IDLE)) begin
                r_tx_reset <= 1'b1;
                r_grant    <= '0;
                r_rr_ptr   <= w_next_ptr;
                r_cnt      <= '0;
                r_state    <= w_after_frame;
            end else if (w_finish) begin
                r_grant    <= '0;
                r_rr_ptr   <= w_next_ptr;
                r_cnt      <= '0;
                r_state    <= w_after_frame;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_enable && w_any_req) begin
                            r_grant    <= w_sel_onehot;
                            r_grant_id <= w_sel_id;
                            r_tx_start <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_START;
                        end
                    end
                    S_START: begin
                        r_cnt   <= '0;
                        r_state <= (HEADER_CYCLES > 1) ? S_HEADER : S_PSDU;
                    end
                    S_HEADER: begin
                        if (r_cnt == CW'(HDR_LAST)) begin
                            r_cnt   <= '0;
                            r_state <= S_PSDU;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_PSDU: begin
                        if (w_psdu_last) begin
                            r_cnt   <= '0;
                            r_state <= S_TRAIL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_TRAIL: begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    S_GAP: begin
                        if (w_gap_last) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_grant      = r_grant;
    assign o_grant_id   = r_grant_id;
    assign o_tx_start   = r_tx_start;
    assign o_tx_reset   = r_tx_reset;
    assign o_busy       = (r_state != S_IDLE);
    assign o_data_ack   = (r_state == S_PSDU) ? r_grant : '0;
    assign o_tx_input   = (r_state == S_PSDU) && i_data[r_grant_id];
    assign o_frame_done = w_finish && !i_abort;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: directed bench with a grant-order scoreboard and a serial source model.
// Expected owners are queued when requests are driven and popped on every TxStart.
module tb_tx_frame_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned HDR     = 139;
    localparam int unsigned PSDU    = 128;
    localparam int unsigned TRL     = 2;
    localparam int unsigned GAP     = 16;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic               enable = 1'b1;
    logic               abort  = 1'b0;
    logic [NUM_REQ-1:0] req    = '0;
    logic [NUM_REQ-1:0] data;
    logic [NUM_REQ-1:0] o_grant;
    logic [1:0]         o_grant_id;
    logic [NUM_REQ-1:0] o_data_ack;
    logic               o_tx_start;
    logic               o_tx_input;
    logic               o_tx_reset;
    logic               o_busy;
    logic               o_frame_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned exp_q[$];
    int unsigned src_idx[NUM_REQ];
    bit          mon_en = 1'b0;
    bit          chk_gap = 1'b0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          ack_cnt = 0;
    int          start_cyc = 0;
    int          last_ack_cyc = 0;
    int          drop_cyc = 0;
    bit          drop_valid = 1'b0;
    bit          first_pending = 1'b0;
    int unsigned owner = 0;
    logic [NUM_REQ-1:0] prev_ack = '0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    always #5 clk = ~clk;

    tx_frame_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .HEADER_CYCLES (HDR),
        .PSDU_BITS     (PSDU),
        .TRAILER_CYCLES(TRL),
        .GAP_CYCLES    (GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_req       (req),
        .i_data      (data),
        .i_abort     (abort),
        .o_grant     (o_grant),
        .o_grant_id  (o_grant_id),
        .o_data_ack  (o_data_ack),
        .o_tx_start  (o_tx_start),
        .o_tx_input  (o_tx_input),
        .o_tx_reset  (o_tx_reset),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
    );

    function automatic logic pat(input int unsigned src, input int unsigned k);
        int unsigned h;
        h = (k * 32'd2654435761) ^ (src * 32'd97) ^ (k >> 3);
        return h[20] ^ h[9];
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
        assign data[g] = pat(g, src_idx[g]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int limit);
        int n = 0;
        while (start_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_start", 32'(start_cnt >= target), 1);
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_ack(input int limit);
        int n = 0;
        while (o_data_ack == '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ack", 32'(o_data_ack != '0), 1);
    endtask

    // Source model: a bit is consumed at the edge ending an ack cycle, so advance at the following negedge.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) if (prev_ack[i]) src_idx[i]++;
        #1;
        cyc++;
        if (mon_en) begin
            chk("grant_onehot0", 32'($onehot0(o_grant)), 1);
            if (prev_grant != '0 && o_grant == '0) begin
                drop_cyc   = cyc;
                drop_valid = 1'b1;
            end
            if (!rst_n) drop_valid = 1'b0;
            if (o_tx_start) begin
                chk("start_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    owner = exp_q.pop_front();
                    chk("grant_id", 32'(o_grant_id), owner);
                    chk("grant_vec", 32'(o_grant), 32'(1) << owner);
                end
                // Grant is low for GAP cycles plus the single IDLE decision cycle.
                if (chk_gap && drop_valid) chk("gap_len", cyc - drop_cyc, GAP + 1);
                start_cnt++;
                start_cyc     = cyc;
                ack_cnt       = 0;
                first_pending = 1'b1;
            end
            if (o_data_ack != '0) begin
                if (first_pending) chk("hdr_latency", cyc - start_cyc, HDR);
                first_pending = 1'b0;
                chk("ack_vec", 32'(o_data_ack), 32'(1) << owner);
                chk("tx_input", 32'(o_tx_input), 32'(pat(owner, src_idx[owner])));
                ack_cnt++;
                last_ack_cyc = cyc;
            end else begin
                chk("tx_input_idle", 32'(o_tx_input), 0);
            end
            if (o_frame_done) begin
                done_cnt++;
                chk("psdu_len", ack_cnt, PSDU);
                chk("trail_len", cyc - last_ack_cyc, TRL);
            end
        end
        prev_ack   = o_data_ack;
        prev_grant = o_grant;
    end

    initial begin
        tick(4);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_grant_id", 32'(o_grant_id), 0);
        chk("rst_tx_reset", 32'(o_tx_reset), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_tx_start", 32'(o_tx_start), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        chk("tx_reset_hold", 32'(o_tx_reset), 1);
        tick(1);
        chk("tx_reset_release", 32'(o_tx_reset), 0);

        // Single source 1.
        exp_q.push_back(1);
        req = 4'b0010;
        wait_starts(1, 50);
        req = 4'b0000;
        wait_done(1, 500);
        tick(GAP + 4);
        chk("idle_after_frame", 32'(o_busy), 0);

        // Fresh reset so round-robin restarts at index 0.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        for (int unsigned k = 0; k < 5; k++) exp_q.push_back(k % NUM_REQ);
        req     = 4'b1111;
        chk_gap = 1'b1;
        for (int f = 2; f <= 6; f++) wait_starts(f, 400);
        req = 4'b0000;
        wait_done(6, 500);
        chk_gap = 1'b0;
        tick(GAP + 4);

        // Abort on PSDU bit 50 of source 1; next grant must go to source 2.
        exp_q.push_back(1);
        exp_q.push_back(2);
        req = 4'b1111;
        wait_starts(7, 50);
        chk_gap = 1'b1;
        wait_ack(300);
        tick(50);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_tx_reset", 32'(o_tx_reset), 1);
        chk("abort_grant", 32'(o_grant), 0);
        chk("abort_busy", 32'(o_busy), 1);
        chk("abort_ack", 32'(o_data_ack), 0);
        tick(1);
        chk("abort_tx_reset_pulse", 32'(o_tx_reset), 0);
        wait_starts(8, 100);
        chk("abort_no_done", done_cnt, 6);
        req     = 4'b0000;
        chk_gap = 1'b0;
        wait_done(7, 500);
        tick(GAP + 4);

        // Enable dropped mid-frame: frame completes, then no new grant.
        exp_q.push_back(0);
        req = 4'b0011;
        wait_starts(9, 50);
        enable = 1'b0;
        wait_done(8, 500);
        tick(60);
        chk("disabled_no_start", start_cnt, 9);
        chk("disabled_busy", 32'(o_busy), 0);
        chk("disabled_grant", 32'(o_grant), 0);
        exp_q.push_back(1);
        enable = 1'b1;
        wait_starts(10, 50);
        req = 4'b0000;
        wait_done(9, 500);
        tick(GAP + 4);

        // Reset in the middle of the PSDU.
        exp_q.push_back(3);
        req = 4'b1000;
        wait_starts(11, 50);
        req = 4'b0000;
        wait_ack(300);
        tick(10);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_grant", 32'(o_grant), 0);
        chk("midrst_grant_id", 32'(o_grant_id), 0);
        chk("midrst_tx_reset", 32'(o_tx_reset), 1);
        chk("midrst_busy", 32'(o_busy), 0);
        chk("midrst_ack", 32'(o_data_ack), 0);
        chk("midrst_tx_start", 32'(o_tx_start), 0);
        chk("midrst_frame_done", 32'(o_frame_done), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_busy", 32'(o_busy), 0);
        chk("post_rst_tx_reset", 32'(o_tx_reset), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_done", done_cnt, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
